// File: rtl/split32_rr_sched_pkg.sv
// Shared defaults and FSM state encoding for the split32 round-robin scheduler.
package split32_rr_sched_pkg;
   localparam int N_DEF        = 32;
   localparam int IDW_DEF      = $clog2(N_DEF);
   localparam int HOLD_W_DEF   = 8;
   localparam int HOLD_MAX_DEF = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_e;
endpackage

// File: rtl/split32_rr_sched_if.sv
// Requester-side bundle: request/mask/done in, grant vector plus status out.
interface split32_rr_sched_if
   import split32_rr_sched_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int IDW = IDW_DEF
);
   logic [N-1:0]   req_i;
   logic [N-1:0]   mask_i;
   logic           done_i;
   logic [N-1:0]   gnt_o;
   logic           gnt_valid_o;
   logic [IDW-1:0] gnt_id_o;
   logic           timeout_o;
   logic           busy_o;

   modport slave (
      input  req_i, mask_i, done_i,
      output gnt_o, gnt_valid_o, gnt_id_o, timeout_o, busy_o
   );

   modport master (
      output req_i, mask_i, done_i,
      input  gnt_o, gnt_valid_o, gnt_id_o, timeout_o, busy_o
   );
endinterface

// File: rtl/split32_rr_sched_rr_pick.sv
// Combinational round-robin picker: first eligible lane after ptr, wrapping N-1 -> 0.
module rr_pick
   import split32_rr_sched_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int IDW = IDW_DEF
) (
   input  logic [N-1:0]   elig_i,
   input  logic [IDW-1:0] ptr_i,
   output logic           found_o,
   output logic [IDW-1:0] idx_o
);
   logic [IDW:0]   start;
   logic [N-1:0]   rot;
   logic [IDW-1:0] ffs;
   logic [IDW:0]   sum;

   // start is 1..N; a shift by N on the doubled vector yields elig_i unrotated
   assign start = {1'b0, ptr_i} + (IDW+1)'(1);
   assign rot   = N'({elig_i, elig_i} >> start);

   always_comb begin
      found_o = 1'b0;
      ffs     = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (rot[k]) begin
            found_o = 1'b1;
            ffs     = IDW'(k);
         end
      end
   end

   always_comb begin
      sum = {1'b0, ffs} + start;
      if (sum >= (IDW+1)'(N))
         sum = sum - (IDW+1)'(N);
   end

   assign idx_o = sum[IDW-1:0];
endmodule

// File: rtl/split32_rr_sched.sv
// Round-robin grant of one lane at a time with release on done, request/mask drop or hold timeout,
// followed by a one-cycle gap before the next arbitration.
module split32_rr_sched
   import split32_rr_sched_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int IDW      = IDW_DEF,
   parameter int HOLD_MAX = HOLD_MAX_DEF,
   parameter int HOLD_W   = HOLD_W_DEF
) (
   input logic               clk,
   input logic               rst,
   split32_rr_sched_if.slave bus
);
   state_e         state_q;
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] gnt_id_q;
   logic [N-1:0]   gnt_q;
   logic           gnt_valid_q;
   logic           timeout_q;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic [N-1:0]   elig;
   logic           found;
   logic [IDW-1:0] win;
   logic           hold_hit;
   logic           early_rel;

   assign elig = bus.req_i & bus.mask_i;

   rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .elig_i  (elig),
      .ptr_i   (ptr_q),
      .found_o (found),
      .idx_o   (win)
   );

   assign hold_d    = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
   assign hold_hit  = (hold_q == HOLD_W'(HOLD_MAX-1));
   // Any holder-side release cause; when present it masks the timeout pulse
   assign early_rel = bus.done_i | ~bus.req_i[gnt_id_q] | ~bus.mask_i[gnt_id_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= IDW'(N-1);
         gnt_id_q    <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_q      <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (found) begin
                  gnt_q       <= N'(1) << win;
                  gnt_valid_q <= 1'b1;
                  gnt_id_q    <= win;
                  ptr_q       <= win;
                  hold_q      <= '0;
                  state_q     <= GRANT;
               end
            end
            GRANT: begin
               hold_q <= hold_d;
               if (hold_hit || early_rel) begin
                  gnt_q       <= '0;
                  gnt_valid_q <= 1'b0;
                  timeout_q   <= hold_hit & ~early_rel;
                  state_q     <= GAP;
               end
            end
            GAP:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt_o       = gnt_q;
   assign bus.gnt_valid_o = gnt_valid_q;
   assign bus.gnt_id_o    = gnt_id_q;
   assign bus.timeout_o   = timeout_q;
   assign bus.busy_o      = (state_q != IDLE);
endmodule
